fetcher: RTL and testbench



---
 rtl/fetcher.sv | 207 ++++++++++++++++++++
 tb/tb_fetcher.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetcher.sv
// fetcher: instruction fetch stage feeding the decoder.
//
// Owns the fetch PC and issues one single-beat read at a time to
// instruction memory. Returned words go into a small prefetch queue whose
// head is presented to the decoder over a valid/ready handshake. A redirect
// from execute flushes the queue, restarts fetch at REDIRECT_PC, and discards
// any response still in flight.
//
// Parameters:
//   QUEUE_DEPTH  prefetch queue entries (power of two, >= 2)
//   RESET_PC     byte address of the first fetch after reset
//
// Ports:
//   CLK, RSTN                 clock, asynchronous active-low reset
//   IMEM_REQ, IMEM_ADDR       registered one-cycle read request + byte address
//   IMEM_RVALID, IMEM_RDATA   read response (>= 1 cycle after the request)
//   REDIRECT, REDIRECT_PC     execute-stage redirect strobe + new fetch address
//   INST_VALID, INST_READY    decoder handshake on the queue head
//   INST, INST_PC             queue head instruction and its byte address
//
// Optional build macro FETCHER_PERF_EN adds:
//   PERF_FETCHED    instructions handed to the decoder (saturating)
//   PERF_DISCARDED  flushed queue entries + dropped responses (saturating)

module fetcher #(
    parameter int          QUEUE_DEPTH = 2,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        CLK,
    input  logic        RSTN,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        INST_VALID,
    input  logic        INST_READY,
    output logic [31:0] INST,
    output logic [31:0] INST_PC
`ifdef FETCHER_PERF_EN
    ,
    output logic [31:0] PERF_FETCHED,
    output logic [31:0] PERF_DISCARDED
`endif
);

    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = PW + 1;   // occupancy counter holds 0..QUEUE_DEPTH
    localparam int OW = CW + 1;   // headroom for count + push - pop

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   q_inst [QUEUE_DEPTH];
    logic [31:0]   q_pc   [QUEUE_DEPTH];

    logic          rsp_hit, push, pop, issue;
    logic [OW-1:0] occ_next;
    logic [31:0]   push_pc;
    logic [CW-1:0] cnt_after_pop;
    logic [PW-1:0] rd_next;
    logic          head_valid_d;
    logic [31:0]   head_inst_d, head_pc_d;

    // The low two redirect address bits never reach the PC.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^REDIRECT_PC[1:0];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue) state_d = S_WAIT;
            S_WAIT: begin
                // A response frees the slot; the next issue may be decided in
                // the same cycle. With REDIRECT, issue is 0 so this lands in IDLE.
                if (IMEM_RVALID)   state_d = issue ? S_WAIT : S_IDLE;
                else if (REDIRECT) state_d = S_DRAIN;
            end
            S_DRAIN: if (IMEM_RVALID) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / datapath controls ----------------
    always_comb begin
        rsp_hit  = (state_q == S_WAIT) && IMEM_RVALID;
        push     = rsp_hit && !REDIRECT;
        // A handshake coinciding with a redirect is void.
        pop      = INST_VALID && INST_READY && !REDIRECT;
        occ_next = {1'b0, count_q} + OW'(push) - OW'(pop);
        // Space is reserved at issue time so the response can always be pushed.
        issue    = !REDIRECT && ((state_q == S_IDLE) || rsp_hit)
                   && (occ_next < OW'(QUEUE_DEPTH));
        push_pc  = fetch_pc_q - 32'd4;
    end

    // ---------------- fetch PC and request ----------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            fetch_pc_q <= RESET_PC;
            IMEM_REQ   <= 1'b0;
            IMEM_ADDR  <= 32'h0;
        end else begin
            IMEM_REQ <= issue;
            if (issue) IMEM_ADDR <= fetch_pc_q;
            if (REDIRECT)   fetch_pc_q <= {REDIRECT_PC[31:2], 2'b00};
            else if (issue) fetch_pc_q <= fetch_pc_q + 32'd4;
        end
    end

    // ---------------- prefetch queue ----------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (REDIRECT) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= occ_next[CW-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            q_inst[wr_ptr_q] <= IMEM_RDATA;
            q_pc[wr_ptr_q]   <= push_pc;
        end
    end

    // Registered head: precompute what the head will be after this edge so
    // the outputs come straight from flops. An empty queue taking a push
    // bypasses the storage array.
    always_comb begin
        cnt_after_pop = count_q - CW'(pop);
        rd_next       = rd_ptr_q + PW'(pop);
        head_valid_d  = 1'b0;
        head_inst_d   = INST;
        head_pc_d     = INST_PC;
        if (!REDIRECT) begin
            head_valid_d = (cnt_after_pop != '0) || push;
            if (cnt_after_pop != '0) begin
                head_inst_d = q_inst[rd_next];
                head_pc_d   = q_pc[rd_next];
            end else if (push) begin
                head_inst_d = IMEM_RDATA;
                head_pc_d   = push_pc;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            INST_VALID <= 1'b0;
            INST       <= 32'h0;
            INST_PC    <= 32'h0;
        end else begin
            INST_VALID <= head_valid_d;
            INST       <= head_inst_d;
            INST_PC    <= head_pc_d;
        end
    end

`ifdef FETCHER_PERF_EN
    // ---------------- performance counters ----------------
    logic          drop;
    logic [OW-1:0] disc_inc;
    logic [32:0]   disc_sum;

    always_comb begin
        drop     = IMEM_RVALID && ((state_q == S_DRAIN) || ((state_q == S_WAIT) && REDIRECT));
        disc_inc = (REDIRECT ? {1'b0, count_q} : '0) + OW'(drop);
        disc_sum = {1'b0, PERF_DISCARDED} + 33'(disc_inc);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            PERF_FETCHED   <= 32'h0;
            PERF_DISCARDED <= 32'h0;
        end else begin
            if (pop && (PERF_FETCHED != 32'hFFFF_FFFF))
                PERF_FETCHED <= PERF_FETCHED + 32'd1;
            PERF_DISCARDED <= disc_sum[32] ? 32'hFFFF_FFFF : disc_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetcher.sv
// Randomized bench for fetcher with a transaction-level reference model:
// an expected fetch address, an expected instruction queue, and a memory
// model that answers each request after a chosen latency.
module tb_fetcher;

    // Depth 4 lets a full-ish queue and an outstanding request coexist.
    localparam int          QD  = 4;
    localparam logic [31:0] RPC = 32'h0;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic        INST_VALID;
    logic        INST_READY;
    logic [31:0] INST;
    logic [31:0] INST_PC;
`ifdef FETCHER_PERF_EN
    logic [31:0] PERF_FETCHED;
    logic [31:0] PERF_DISCARDED;
`endif

    always #5 CLK = ~CLK;

    fetcher #(.QUEUE_DEPTH(QD), .RESET_PC(RPC)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .INST_VALID(INST_VALID), .INST_READY(INST_READY),
        .INST(INST), .INST_PC(INST_PC)
`ifdef FETCHER_PERF_EN
        , .PERF_FETCHED(PERF_FETCHED), .PERF_DISCARDED(PERF_DISCARDED)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc, pend_addr, last_req_addr, first_req_addr, first_pop_pc;
    logic [31:0] drv_rpc, rv_rpc;
    bit          pending, pend_dead, drv_ready, drv_redirect, lat_rand;
    bit          redir_on_rv, rv_hit, pop_seen, wrap_seen;
    int          wait_cnt, lat_cur, nreq, nfetch, ndisc, cyc, nvalid, first_valid_cyc;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'h13;
    endfunction

    task automatic do_reset(input bit stray_after);
        RSTN = 1'b0;
        IMEM_RVALID = 1'b0; IMEM_RDATA = 32'h0;
        REDIRECT = 1'b0; REDIRECT_PC = 32'h0; INST_READY = 1'b0;
        #1;
        chk("rst_req",   32'(IMEM_REQ),   32'd0);
        chk("rst_addr",  IMEM_ADDR,       32'h0);
        chk("rst_valid", 32'(INST_VALID), 32'd0);
        chk("rst_inst",  INST,            32'h0);
        chk("rst_pc",    INST_PC,         32'h0);
`ifdef FETCHER_PERF_EN
        chk("rst_perf_f", PERF_FETCHED,   32'h0);
        chk("rst_perf_d", PERF_DISCARDED, 32'h0);
`endif
        mq.delete();
        m_pc = RPC; pending = 0; pend_dead = 0; wait_cnt = 0;
        nreq = 0; nfetch = 0; ndisc = 0; cyc = 0; nvalid = 0; first_valid_cyc = 0;
        drv_ready = 0; drv_redirect = 0; drv_rpc = 32'h0; lat_cur = 1; lat_rand = 0;
        redir_on_rv = 0; rv_hit = 0; pop_seen = 0; wrap_seen = 0;
        last_req_addr = 32'h0; first_req_addr = 32'hFFFF_FFFF; first_pop_pc = 32'hFFFF_FFFF;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        // Optional stray response sampled at the first edge after release.
        IMEM_RVALID = stray_after;
        IMEM_RDATA  = 32'hDEAD_BEEF;
        RSTN = 1'b1;
    endtask

    // One clock: check outputs against the model, drive inputs, advance model.
    task automatic step();
        bit          rv, redir, hs;
        logic [31:0] rpc;
        ent_t        e;
        @(negedge CLK);
        cyc++;
        chk("inst_valid", 32'(INST_VALID), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("inst_pc", INST_PC, mq[0].pc);
            chk("inst",    INST,    mq[0].data);
        end
        if (INST_VALID === 1'b1) begin
            nvalid++;
            if (first_valid_cyc == 0) first_valid_cyc = cyc;
        end
`ifdef FETCHER_PERF_EN
        chk("perf_fetched",   PERF_FETCHED,   32'(nfetch));
        chk("perf_discarded", PERF_DISCARDED, 32'(ndisc));
`endif
        rv = 0;
        if (IMEM_REQ === 1'b1) begin
            chk("req_while_busy", 32'(pending), 32'd0);
            chk("imem_addr", IMEM_ADDR, m_pc);
            if (nreq == 0) first_req_addr = IMEM_ADDR;
            if (nreq != 0 && IMEM_ADDR == 32'h0 && last_req_addr == 32'hFFFF_FFFC) wrap_seen = 1;
            last_req_addr = IMEM_ADDR;
            pend_addr = m_pc;
            m_pc      = m_pc + 32'd4;
            pending   = 1;
            pend_dead = 0;
            wait_cnt  = lat_rand ? int'($urandom_range(1, 4)) : lat_cur;
            nreq++;
            chk("occupancy", 32'((mq.size() + 1) <= QD), 32'd1);
        end else if (pending) begin
            wait_cnt--;
            rv = (wait_cnt == 0);
        end

        redir = drv_redirect;
        rpc   = drv_rpc;
        if (redir_on_rv && rv) begin
            redir = 1; rpc = rv_rpc; redir_on_rv = 0; rv_hit = 1;
        end
        IMEM_RVALID = rv;
        IMEM_RDATA  = rv ? mem_word(pend_addr) : $urandom;
        REDIRECT    = redir;
        REDIRECT_PC = rpc;
        INST_READY  = drv_ready;

        hs = (mq.size() != 0) && drv_ready && !redir;
        if (hs) begin
            e = mq.pop_front();
            nfetch++;
            if (!pop_seen) begin pop_seen = 1; first_pop_pc = e.pc; end
        end
        if (redir) begin
            ndisc += mq.size();
            mq.delete();
            m_pc = rpc & ~32'h3;
            if (pending) pend_dead = 1;
        end
        if (rv) begin
            if (pend_dead) ndisc++;
            else begin
                e.pc = pend_addr; e.data = mem_word(pend_addr);
                mq.push_back(e);
            end
            pending = 0; pend_dead = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bit done;
        RSTN = 1'b1;
        #2;

        // 1: streaming with single-cycle memory
        do_reset(0);
        drv_ready = 1;
        repeat (22) step();
        chk("s1_first_valid_cyc", 32'(first_valid_cyc), 32'd3);
        chk("s1_valid_count",     32'(nvalid),          32'd10);
        chk("s1_req_count",       32'(nreq),            32'd11);

        // 2: decoder stalled, queue fills, one pop frees one slot
        do_reset(0);
        repeat (20) step();
        chk("s2_req_count", 32'(nreq), 32'(QD));
        drv_ready = 1;
        step();
        drv_ready = 0;
        repeat (4) step();
        chk("s2_req_after_pop", 32'(nreq), 32'(QD + 1));
        chk("s2_last_addr", last_req_addr, 32'(QD * 4));

        // 3: redirect with two queued entries and a slow request in flight
        do_reset(0);
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin step(); done = (nreq >= 2); end
        chk("s3_fill_timeout", 32'(done), 32'd1);
        lat_cur = 3;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin step(); done = (mq.size() == 2) && pending; end
        chk("s3_setup_timeout", 32'(done), 32'd1);
        drv_redirect = 1; drv_rpc = 32'h74;
        step();
        drv_redirect = 0;
        step();
        chk("s3_valid_drop", 32'(INST_VALID), 32'd0);
        drv_ready = 1; lat_cur = 1;
        for (int i = 0; i < 40 && !pop_seen; i++) step();
        chk("s3_first_pc", first_pop_pc, 32'h74);
`ifdef FETCHER_PERF_EN
        chk("s3_perf_discarded", PERF_DISCARDED, 32'd3);
`endif

        // 4: redirect in the same cycle as the response
        do_reset(0);
        redir_on_rv = 1; rv_rpc = 32'h8F;
        for (int i = 0; i < 10 && !rv_hit; i++) step();
        chk("s4_rv_hit", 32'(rv_hit), 32'd1);
        step();
        chk("s4_dropped", 32'(INST_VALID), 32'd0);
        n0 = nreq;
        for (int i = 0; i < 10 && nreq == n0; i++) step();
        chk("s4_next_addr", last_req_addr, 32'h8C);
        drv_ready = 1;
        repeat (6) step();
        chk("s4_first_pc", first_pop_pc, 32'h8C);

        // 5: reset while waiting, stray response right after release
        do_reset(0);
        lat_cur = 3;
        for (int i = 0; i < 10 && !pending; i++) step();
        chk("s5_wait_timeout", 32'(pending), 32'd1);
        step();
        do_reset(1);
        drv_ready = 1;
        repeat (10) step();
        chk("s5_first_addr", first_req_addr, RPC);
        chk("s5_first_valid_cyc", 32'(first_valid_cyc), 32'd3);
        chk("s5_first_pc", first_pop_pc, RPC);

        // 6: fetch PC wraps at the top of the address space
        do_reset(0);
        drv_ready = 1; drv_redirect = 1; drv_rpc = 32'hFFFF_FFF6;
        step();
        drv_redirect = 0;
        repeat (16) step();
        chk("s6_wrap", 32'(wrap_seen), 32'd1);

        // 7: random ready / redirect / memory latency
        do_reset(0);
        lat_rand = 1;
        repeat (2000) begin
            drv_ready    = ($urandom_range(0, 9) < 7);
            drv_redirect = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 3))
                0:       drv_rpc = $urandom;
                1:       drv_rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: drv_rpc = 32'($urandom_range(0, 255));
            endcase
            step();
        end
        drv_redirect = 0; drv_ready = 1;
        repeat (20) step();
        chk("s7_progress", 32'(nfetch > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
